// File: rtl/rbus_frame_arbiter.sv
// NUM_CH-to-1 frame-atomic rbus arbiter: header priority pre-select, then round-robin.
// Header ack one cycle after it is seen in IDLE, output one cycle after ack; holds while !i_rdy.
module rbus_frame_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int LEN0_WORDS = 1,
   parameter int LEN1_WORDS = 9,
   parameter int PRIO_EN    = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CH-1:0]           i_stb,
   input  logic [NUM_CH*72-1:0]        i_data,
   output logic [NUM_CH-1:0]           o_ack,
   output logic                        o_stb,
   output logic                        o_sof,
   output logic                        o_eof,
   output logic [$clog2(NUM_CH)-1:0]   o_ch,
   output logic [71:0]                 o_data,
   input  logic                        i_rdy,
   output logic                        o_busy
);

   localparam int CHW     = $clog2(NUM_CH);
   localparam int PRI_HI  = 69;
   localparam int PRI_LO  = 68;
   localparam int LEN_BIT = 39;

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t           state_q, state_d;
   logic [CHW-1:0]   grant_q, grant_d;
   logic [CHW-1:0]   rr_q, rr_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             first_q, first_d;

   logic             stb_q, stb_d;
   logic             sof_q, sof_d;
   logic             eof_q, eof_d;
   logic [CHW-1:0]   ch_q, ch_d;
   logic [71:0]      data_q, data_d;

   logic [71:0]      ch_word [NUM_CH];
   logic [1:0]       max_pri;
   logic [NUM_CH-1:0] cand;
   logic             win_found;
   logic [CHW-1:0]   win_idx;
   logic             out_free;
   logic             accept;
   logic             last_beat;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_word
      assign ch_word[k] = i_data[72*k +: 72];
   end

   // Winner: highest requesting priority (if enabled), then first candidate at/after rr_q.
   always_comb begin
      int j;
      max_pri   = 2'd0;
      cand      = '0;
      win_found = 1'b0;
      win_idx   = '0;
      j         = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (i_stb[k] && (ch_word[k][PRI_HI:PRI_LO] > max_pri)) begin
            max_pri = ch_word[k][PRI_HI:PRI_LO];
         end
      end
      for (int k = 0; k < NUM_CH; k++) begin
         cand[k] = i_stb[k] && ((PRIO_EN == 0) || (ch_word[k][PRI_HI:PRI_LO] == max_pri));
      end
      for (int i = 0; i < NUM_CH; i++) begin
         j = int'(rr_q) + i;
         if (j >= NUM_CH) begin
            j = j - NUM_CH;
         end
         if (!win_found && cand[j]) begin
            win_found = 1'b1;
            win_idx   = CHW'(j);
         end
      end
   end

   assign out_free  = !stb_q || i_rdy;
   assign last_beat = (cnt_q == 5'd1);

   always_comb begin
      o_ack = '0;
      if (state_q == ST_GRANT) begin
         o_ack[grant_q] = i_stb[grant_q] & out_free;
      end
   end

   assign accept = |o_ack;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d = ST_GRANT;
               grant_d = win_idx;
               cnt_d   = ch_word[win_idx][LEN_BIT] ? 5'(LEN1_WORDS) : 5'(LEN0_WORDS);
               first_d = 1'b1;
            end
         end
         ST_GRANT: begin
            if (accept) begin
               cnt_d   = cnt_q - 5'd1;
               first_d = 1'b0;
               if (last_beat) begin
                  state_d = ST_IDLE;
                  rr_d    = (grant_q == CHW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output register: load on accept, hold under backpressure, drop valid once drained.
   always_comb begin
      stb_d  = stb_q;
      sof_d  = sof_q;
      eof_d  = eof_q;
      ch_d   = ch_q;
      data_d = data_q;
      if (accept) begin
         stb_d  = 1'b1;
         sof_d  = first_q;
         eof_d  = last_beat;
         ch_d   = grant_q;
         data_d = ch_word[grant_q];
      end else if (i_rdy) begin
         stb_d = 1'b0;
         sof_d = 1'b0;
         eof_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         first_q <= 1'b0;
         stb_q   <= 1'b0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         ch_q    <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         stb_q   <= stb_d;
         sof_q   <= sof_d;
         eof_q   <= eof_d;
         ch_q    <= ch_d;
         data_q  <= data_d;
      end
   end

   assign o_stb  = stb_q;
   assign o_sof  = sof_q;
   assign o_eof  = eof_q;
   assign o_ch   = ch_q;
   assign o_data = data_q;
   assign o_busy = (state_q == ST_GRANT);

endmodule

// File: tb/tb_rbus_frame_arbiter.sv
// Scoreboard bench: dut0 with header priority, dut1 pure round-robin; sources hold words until acked.
module tb_rbus_frame_arbiter;

   typedef struct packed {
      logic [1:0]  ch;
      logic        sof;
      logic        eof;
      logic [71:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   stb   [2];
   logic [287:0] dat   [2];
   logic [3:0]   ack   [2];
   logic         ostb  [2];
   logic         osof  [2];
   logic         oeof  [2];
   logic [1:0]   och   [2];
   logic [71:0]  odata [2];
   logic         rdy   [2];
   logic         busy  [2];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [71:0] src_q [8][$];
   exp_t        exp_q [2][$];
   int          ack_cyc [$];
   int          out_cyc [$];
   logic [3:0]  acc [2];
   int          sent [8];
   int          gap_after [8];
   int          gap_len [8];
   int          gap_cnt [8];
   logic        tog [2];
   exp_t        e;

   rbus_frame_arbiter #(.NUM_CH(4), .LEN0_WORDS(1), .LEN1_WORDS(9), .PRIO_EN(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .i_stb(stb[0]), .i_data(dat[0]), .o_ack(ack[0]),
      .o_stb(ostb[0]), .o_sof(osof[0]), .o_eof(oeof[0]), .o_ch(och[0]), .o_data(odata[0]),
      .i_rdy(rdy[0]), .o_busy(busy[0]));

   rbus_frame_arbiter #(.NUM_CH(4), .LEN0_WORDS(1), .LEN1_WORDS(9), .PRIO_EN(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_stb(stb[1]), .i_data(dat[1]), .o_ack(ack[1]),
      .o_stb(ostb[1]), .o_sof(osof[1]), .o_eof(oeof[1]), .o_ch(och[1]), .o_data(odata[1]),
      .i_rdy(rdy[1]), .o_busy(busy[1]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Header carries priority and length; body words carry decoy values in those bits.
   function automatic logic [71:0] mk_word(input logic [1:0] prio, input logic len,
                                           input int ch, input int fid, input int idx);
      logic [71:0] w;
      w        = '0;
      w[71:70] = 2'b10;
      w[63:48] = 16'(fid * 257 + 16'h3C00);
      w[31:24] = 8'(fid);
      w[15:8]  = 8'(ch);
      w[7:0]   = 8'(idx);
      if (idx == 0) begin
         w[69:68] = prio;
         w[39]    = len;
      end else begin
         w[69:68] = 2'b11;
         w[39]    = ~len;
         w[47:40] = 8'hA5;
      end
      return w;
   endfunction

   task automatic src_frame(input int d, input int ch, input logic [1:0] prio, input logic len,
                            input int fid, input int n);
      for (int i = 0; i < n; i++) src_q[d*4+ch].push_back(mk_word(prio, len, ch, fid, i));
   endtask

   task automatic exp_frame(input int d, input int ch, input logic [1:0] prio, input logic len,
                            input int fid, input int n);
      exp_t x;
      for (int i = 0; i < n; i++) begin
         x.ch   = 2'(ch);
         x.sof  = (i == 0);
         x.eof  = (i == n - 1);
         x.data = mk_word(prio, len, ch, fid, i);
         exp_q[d].push_back(x);
      end
   endtask

   task automatic clear_tb();
      for (int q = 0; q < 8; q++) begin
         src_q[q].delete();
         sent[q]      = 0;
         gap_after[q] = 255;
         gap_len[q]   = 0;
         gap_cnt[q]   = 0;
      end
      for (int d = 0; d < 2; d++) begin
         exp_q[d].delete();
         stb[d] = '0;
         acc[d] = '0;
         tog[d] = 1'b0;
         rdy[d] = 1'b1;
      end
      ack_cyc.delete();
      out_cyc.delete();
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("reset_outputs", 96'({ostb[d], osof[d], oeof[d], och[d], busy[d], ack[d], odata[d]}), 96'(0));
      end
      clear_tb();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      assert_reset();
   endtask

   task automatic wait_drain(input int d, input int budget);
      int n;
      n = 0;
      while (exp_q[d].size() != 0 && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk_int("drain_timeout", exp_q[d].size(), 0);
      repeat (2) @(negedge clk);
   endtask

   // Source model: sample acceptance mid-cycle, advance queues just after the edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) acc[d] = stb[d] & ack[d];
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
               if (acc[d][k] && src_q[d*4+k].size() > 0) begin
                  void'(src_q[d*4+k].pop_front());
                  sent[d*4+k]++;
               end
               if (sent[d*4+k] == gap_after[d*4+k] && gap_cnt[d*4+k] < gap_len[d*4+k]) begin
                  stb[d][k] = 1'b0;
                  gap_cnt[d*4+k]++;
               end else if (src_q[d*4+k].size() > 0) begin
                  stb[d][k] = 1'b1;
                  dat[d][72*k +: 72] = src_q[d*4+k][0];
               end else begin
                  stb[d][k] = 1'b0;
               end
            end
            rdy[d] = tog[d] ? ~rdy[d] : 1'b1;
         end
      end
   end

   // Monitor: ack legality and scoreboard comparison on every transfer.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            if (ack[d] != 4'b0) begin
               chk("ack_rule", 96'({$onehot(ack[d]), (ack[d] & ~stb[d]) == 4'b0, (!ostb[d] || rdy[d])}),
                   96'(3'b111));
               if (d == 0) ack_cyc.push_back(cyc);
            end
            if (ostb[d] && rdy[d]) begin
               if (exp_q[d].size() == 0) begin
                  chk("unexpected_out", 96'({och[d], osof[d], oeof[d], odata[d]}), 96'(0));
               end else begin
                  e = exp_q[d].pop_front();
                  chk("out_word", 96'({och[d], osof[d], oeof[d], odata[d]}), 96'(e));
               end
               if (d == 0) out_cyc.push_back(cyc);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int t0;
      int n;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) dat[d] = '0;
      clear_tb();
      repeat (2) @(negedge clk);
      #2;
      assert_reset();

      // Reset mid-frame
      @(negedge clk);
      src_frame(0, 0, 2'd0, 1'b1, 1, 9);
      exp_frame(0, 0, 2'd0, 1'b1, 1, 9);
      n = 0;
      while (out_cyc.size() < 3 && n < 50) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk_int("t1_words_before_reset", out_cyc.size(), 3);
      chk_int("t1_busy_mid_frame", int'(busy[0]), 1);
      assert_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #2;
         chk("t1_idle_after_reset", 96'({ack[0], ostb[0]}), 96'(0));
      end

      // Single long frame, full throughput
      do_reset();
      @(negedge clk);
      t0 = cyc;
      src_frame(0, 0, 2'd1, 1'b1, 2, 9);
      exp_frame(0, 0, 2'd1, 1'b1, 2, 9);
      wait_drain(0, 100);
      chk_int("t2_ack_count", ack_cyc.size(), 9);
      if (ack_cyc.size() == 9) begin
         chk_int("t2_first_ack", ack_cyc[0], t0 + 2);
         chk_int("t2_ack_run", ack_cyc[8] - ack_cyc[0], 8);
      end
      if (out_cyc.size() > 0) chk_int("t2_first_out", out_cyc[0], t0 + 3);
      chk_int("t2_busy_after", int'(busy[0]), 0);

      // Four equal-priority single-word requesters, round-robin
      do_reset();
      @(negedge clk);
      t0 = cyc;
      src_frame(0, 0, 2'd2, 1'b0, 10, 1);
      src_frame(0, 0, 2'd2, 1'b0, 11, 1);
      src_frame(0, 1, 2'd2, 1'b0, 12, 1);
      src_frame(0, 2, 2'd2, 1'b0, 13, 1);
      src_frame(0, 3, 2'd2, 1'b0, 14, 1);
      exp_frame(0, 0, 2'd2, 1'b0, 10, 1);
      exp_frame(0, 1, 2'd2, 1'b0, 12, 1);
      exp_frame(0, 2, 2'd2, 1'b0, 13, 1);
      exp_frame(0, 3, 2'd2, 1'b0, 14, 1);
      exp_frame(0, 0, 2'd2, 1'b0, 11, 1);
      wait_drain(0, 100);
      chk_int("t3_ack_count", ack_cyc.size(), 5);
      if (ack_cyc.size() == 5) begin
         chk_int("t3_first_ack", ack_cyc[0], t0 + 2);
         for (int i = 1; i < 5; i++) chk_int("t3_header_spacing", ack_cyc[i] - ack_cyc[i-1], 2);
      end

      // Priority pre-selection vs pure round-robin
      do_reset();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         src_frame(d, 1, 2'b01, 1'b0, 20, 1);
         src_frame(d, 3, 2'b11, 1'b0, 21, 1);
      end
      exp_frame(0, 3, 2'b11, 1'b0, 21, 1);
      exp_frame(0, 1, 2'b01, 1'b0, 20, 1);
      exp_frame(1, 1, 2'b01, 1'b0, 20, 1);
      exp_frame(1, 3, 2'b11, 1'b0, 21, 1);
      wait_drain(0, 50);
      wait_drain(1, 50);

      // Backpressure: i_rdy toggles every cycle
      do_reset();
      @(negedge clk);
      tog[0] = 1'b1;
      src_frame(0, 0, 2'd0, 1'b1, 30, 9);
      exp_frame(0, 0, 2'd0, 1'b1, 30, 9);
      wait_drain(0, 200);
      tog[0] = 1'b0;
      chk_int("t5_ack_count", ack_cyc.size(), 9);

      // Stalling source holds the grant; higher-priority ch0 waits
      do_reset();
      gap_after[2] = 3;
      gap_len[2]   = 3;
      @(negedge clk);
      src_frame(0, 2, 2'd0, 1'b1, 40, 9);
      @(negedge clk);
      src_frame(0, 0, 2'd3, 1'b0, 41, 1);
      exp_frame(0, 2, 2'd0, 1'b1, 40, 9);
      exp_frame(0, 0, 2'd3, 1'b0, 41, 1);
      wait_drain(0, 100);
      chk_int("t6_ack_count", ack_cyc.size(), 10);
      if (ack_cyc.size() == 10) begin
         chk_int("t6_gap", ack_cyc[3] - ack_cyc[2], 4);
         chk_int("t6_next_grant", ack_cyc[9] - ack_cyc[8], 2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
